mvm_rf_loader: RTL and testbench

//  Synthesizable AXI-Stream register-file weight loader in front of mvm_top's slave port.

---
 rtl/mvm_loader_pkg.sv | 51 +++++
 rtl/axis_out_reg.sv | 59 +++++
 rtl/mvm_rf_loader.sv | 205 ++++++++++++++++++++
 tb/tb_mvm_rf_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_loader_pkg.sv
// Shared constants, types and helpers for the MVM register-file weight loader.
//
// Contents:
//   - Data-path widths (word, TID, TDEST, RF address, RF select lanes, TUSER).
//   - Widths of the configuration count ports.
//   - TUSER field layout: {one-hot RF select, opcode, RF address}.
//   - Loader FSM state enum.
//   - build_tuser(): assembles one RF-write TUSER word.
package mvm_loader_pkg;

  localparam int DATAW    = 512;
  localparam int IDW      = 32;
  localparam int DESTW    = 12;
  localparam int RF_ADDRW = 9;
  localparam int NUM_RF   = 64;
  localparam int USERW    = 11 + NUM_RF;
  localparam int DCNTW    = 4;

  // Count widths: RF count must be able to hold NUM_RF itself, and the word
  // count must be able to hold a full RF (2**RF_ADDRW words).
  localparam int RFCNTW = $clog2(NUM_RF + 1);
  localparam int WCNTW  = RF_ADDRW + 1;

  // TUSER layout
  localparam int ADDR_LSB = 0;
  localparam int OP_LSB   = 9;
  localparam int SEL_LSB  = 11;

  localparam logic [1:0] RF_WRITE_OP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // RF address in the low field, write opcode above it, and a single select
  // bit for the target RF in the upper lanes.
  function automatic logic [USERW-1:0] build_tuser(
    input logic [RF_ADDRW-1:0] addr,
    input logic [RFCNTW-1:0]   rf_idx
  );
    logic [USERW-1:0] t;
    t = '0;
    t[ADDR_LSB +: RF_ADDRW] = addr;
    t[OP_LSB +: 2]          = RF_WRITE_OP;
    t = t | (USERW'(1) << (SEL_LSB + int'(rf_idx)));
    return t;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register.
//
// Holds a single beat of W bits. A new beat is loaded whenever the register
// is empty or its current beat is leaving in the same cycle, so back-to-back
// beats flow at full throughput while the payload stays frozen under
// backpressure.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   in_valid    upstream offers a beat
//   in_ready    register can accept a beat this cycle
//   in_data     upstream payload
//   out_valid   registered TVALID
//   out_ready   downstream TREADY
//   out_data    registered payload
module axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  always_comb begin
    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/mvm_rf_loader.sv
// AXI-Stream register-file weight loader in front of an MVM NoC slave port.
//
// Streams weight words from a source into one or more NoC destinations as
// single-beat RF-write packets. Word order is: RF address innermost, then RF
// index, then destination.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      start a job (only sampled while idle)
//   cfg_dest_base/step         first TDEST and TDEST increment per destination
//   cfg_num_dest/rf/words      job dimensions
//   cfg_addr_base              first RF address (wraps modulo RF depth)
//   s_valid/s_ready/s_data     weight-word source
//   axis_m_*                   AXI-Stream master towards the NoC
//   busy                       job in progress
//   done                       one-cycle pulse when a job ends
//   cfg_err                    last START carried an illegal configuration
module mvm_rf_loader
  import mvm_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DESTW-1:0]    cfg_dest_base,
  input  logic [DESTW-1:0]    cfg_dest_step,
  input  logic [DCNTW-1:0]    cfg_num_dest,
  input  logic [RFCNTW-1:0]   cfg_num_rf,
  input  logic [WCNTW-1:0]    cfg_num_words,
  input  logic [RF_ADDRW-1:0] cfg_addr_base,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATAW-1:0]    s_data,
  output logic                axis_m_tvalid,
  input  logic                axis_m_tready,
  output logic [DATAW-1:0]    axis_m_tdata,
  output logic                axis_m_tlast,
  output logic [IDW-1:0]      axis_m_tid,
  output logic [USERW-1:0]    axis_m_tuser,
  output logic [DESTW-1:0]    axis_m_tdest,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int PW = DATAW + 1 + IDW + USERW + DESTW;

  state_e state_q, state_d;

  // Job configuration captured at START
  logic [DESTW-1:0]    dest_step_q, dest_step_d;
  logic [DCNTW-1:0]    num_dest_q, num_dest_d;
  logic [RFCNTW-1:0]   num_rf_q, num_rf_d;
  logic [WCNTW-1:0]    num_words_q, num_words_d;
  logic [RF_ADDRW-1:0] addr_base_q, addr_base_d;

  // Position within the job
  logic [WCNTW-1:0]    word_q, word_d;
  logic [RFCNTW-1:0]   rf_q, rf_d;
  logic [DCNTW-1:0]    dst_q, dst_d;
  logic [RF_ADDRW-1:0] addr_q, addr_d;
  logic [DESTW-1:0]    dest_q, dest_d;

  logic done_q, done_d;
  logic cfg_err_q, cfg_err_d;

  logic cfg_zero, cfg_bad, start_idle;
  logic last_word, last_rf, last_dst;
  logic accept, run, load_valid;
  logic out_in_ready, out_valid;
  logic [PW-1:0] beat, out_data;

  assign cfg_zero   = (cfg_num_dest == '0) || (cfg_num_rf == '0) || (cfg_num_words == '0);
  assign cfg_bad    = (cfg_num_rf > RFCNTW'(NUM_RF)) || (cfg_num_words > WCNTW'(1 << RF_ADDRW));
  assign start_idle = (state_q == ST_IDLE) && start;

  assign last_word = (word_q == num_words_q - WCNTW'(1));
  assign last_rf   = (rf_q == num_rf_q - RFCNTW'(1));
  assign last_dst  = (dst_q == num_dest_q - DCNTW'(1));

  assign accept = s_valid && s_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Empty or illegal jobs never leave IDLE; they only pulse DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && !cfg_zero && !cfg_bad) state_d = ST_RUN;
      ST_RUN:   if (accept && last_word && last_rf && last_dst) state_d = ST_DRAIN;
      ST_DRAIN: if (!out_valid || axis_m_tready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    run        = (state_q == ST_RUN);
    s_ready    = run && out_in_ready;
    load_valid = run && s_valid;
    busy       = (state_q != ST_IDLE);
    done_d     = 1'b0;
    cfg_err_d  = cfg_err_q;
    if (start_idle) begin
      cfg_err_d = cfg_bad;
      done_d    = cfg_zero || cfg_bad;
    end
    if ((state_q == ST_DRAIN) && (!out_valid || axis_m_tready)) done_d = 1'b1;
  end

  // Configuration capture and nested address/RF/destination counters. The
  // TDEST accumulator adds the step once per destination instead of multiplying.
  always_comb begin
    dest_step_d = dest_step_q;
    num_dest_d  = num_dest_q;
    num_rf_d    = num_rf_q;
    num_words_d = num_words_q;
    addr_base_d = addr_base_q;
    word_d      = word_q;
    rf_d        = rf_q;
    dst_d       = dst_q;
    addr_d      = addr_q;
    dest_d      = dest_q;
    if (start_idle) begin
      dest_step_d = cfg_dest_step;
      num_dest_d  = cfg_num_dest;
      num_rf_d    = cfg_num_rf;
      num_words_d = cfg_num_words;
      addr_base_d = cfg_addr_base;
      word_d      = '0;
      rf_d        = '0;
      dst_d       = '0;
      addr_d      = cfg_addr_base;
      dest_d      = cfg_dest_base;
    end else if (accept) begin
      if (!last_word) begin
        word_d = word_q + WCNTW'(1);
        addr_d = addr_q + RF_ADDRW'(1);
      end else begin
        word_d = '0;
        addr_d = addr_base_q;
        if (!last_rf) begin
          rf_d = rf_q + RFCNTW'(1);
        end else begin
          rf_d   = '0;
          dst_d  = dst_q + DCNTW'(1);
          dest_d = dest_q + dest_step_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_step_q <= '0;
      num_dest_q  <= '0;
      num_rf_q    <= '0;
      num_words_q <= '0;
      addr_base_q <= '0;
      word_q      <= '0;
      rf_q        <= '0;
      dst_q       <= '0;
      addr_q      <= '0;
      dest_q      <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      dest_step_q <= dest_step_d;
      num_dest_q  <= num_dest_d;
      num_rf_q    <= num_rf_d;
      num_words_q <= num_words_d;
      addr_base_q <= addr_base_d;
      word_q      <= word_d;
      rf_q        <= rf_d;
      dst_q       <= dst_d;
      addr_q      <= addr_d;
      dest_q      <= dest_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Beat is built from the counters as they stand when the word is accepted.
  assign beat = {s_data, 1'b1, IDW'(dst_q), build_tuser(addr_q, rf_q), dest_q};

  axis_out_reg #(.W(PW)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (load_valid),
    .in_ready  (out_in_ready),
    .in_data   (beat),
    .out_valid (out_valid),
    .out_ready (axis_m_tready),
    .out_data  (out_data)
  );

  assign axis_m_tvalid = out_valid;
  assign {axis_m_tdata, axis_m_tlast, axis_m_tid, axis_m_tuser, axis_m_tdest} = out_data;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_mvm_rf_loader.sv
// Self-checking bench for mvm_rf_loader: a queue-based model of the expected
// beat sequence is built per job from nested loops, and a monitor compares
// every output handshake and every stalled cycle against it.
module tb_mvm_rf_loader;
   import mvm_loader_pkg::*;

   typedef struct {
      logic [DATAW-1:0] data;
      logic [USERW-1:0] tuser;
      logic [DESTW-1:0] tdest;
      logic [IDW-1:0]   tid;
   } beat_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [DESTW-1:0]    cfg_dest_base = '0;
   logic [DESTW-1:0]    cfg_dest_step = '0;
   logic [DCNTW-1:0]    cfg_num_dest = '0;
   logic [RFCNTW-1:0]   cfg_num_rf = '0;
   logic [WCNTW-1:0]    cfg_num_words = '0;
   logic [RF_ADDRW-1:0] cfg_addr_base = '0;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic [DATAW-1:0]    s_data = '0;
   logic                axis_m_tvalid;
   logic                axis_m_tready = 1'b0;
   logic [DATAW-1:0]    axis_m_tdata;
   logic                axis_m_tlast;
   logic [IDW-1:0]      axis_m_tid;
   logic [USERW-1:0]    axis_m_tuser;
   logic [DESTW-1:0]    axis_m_tdest;
   logic                busy;
   logic                done;
   logic                cfg_err;

   always #5 clk = ~clk;

   mvm_rf_loader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .cfg_dest_base (cfg_dest_base),
      .cfg_dest_step (cfg_dest_step),
      .cfg_num_dest  (cfg_num_dest),
      .cfg_num_rf    (cfg_num_rf),
      .cfg_num_words (cfg_num_words),
      .cfg_addr_base (cfg_addr_base),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .axis_m_tvalid (axis_m_tvalid),
      .axis_m_tready (axis_m_tready),
      .axis_m_tdata  (axis_m_tdata),
      .axis_m_tlast  (axis_m_tlast),
      .axis_m_tid    (axis_m_tid),
      .axis_m_tuser  (axis_m_tuser),
      .axis_m_tdest  (axis_m_tdest),
      .busy          (busy),
      .done          (done),
      .cfg_err       (cfg_err)
   );

   int testsRun = 0;
   int testsFailed = 0;

   beat_t            expQ[$];
   beat_t            gotQ[$];
   logic [DATAW-1:0] srcWords[$];
   int               srcIdx = 0;
   bit               srcActive = 1'b0;
   int               readyPct = 100;
   int               gapPct = 0;
   int               cycleCount = 0;
   int               doneCount = 0;
   int               doneCycle = 0;
   int               lastHsCycle = 0;
   int               startCycle = 0;
   int               expTotal = 0;
   bit               expErr = 1'b0;

   task automatic checkOutput(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DATAW-1:0] randWord();
      logic [DATAW-1:0] w;
      for (int i = 0; i < DATAW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [USERW-1:0] gotTuser(input int i);
      if (gotQ.size() > i) return gotQ[i].tuser;
      return '1;
   endfunction

   function automatic logic [DESTW-1:0] gotTdest(input int i);
      if (gotQ.size() > i) return gotQ[i].tdest;
      return '1;
   endfunction

   // Source and sink driver: random TREADY and random S_VALID gaps each cycle.
   initial begin
      forever begin
         @(negedge clk);
         axis_m_tready = (int'($urandom_range(99)) < readyPct);
         if (srcActive && srcIdx < srcWords.size() && int'($urandom_range(99)) >= gapPct) begin
            s_valid = 1'b1;
            s_data  = srcWords[srcIdx];
         end else begin
            s_valid = 1'b0;
            s_data  = randWord();
         end
         #1;
         if (s_valid && s_ready) srcIdx++;
      end
   end

   // Monitor: every handshake is checked against the model queue, and any
   // stalled beat must still be presented unchanged on the following cycle.
   initial begin : monitor
      logic [DATAW-1:0] prevData;
      logic [119:0]     prevMeta;
      logic [119:0]     meta;
      bit               prevStall;
      beat_t            e;
      beat_t            g;
      prevStall = 1'b0;
      prevData  = '0;
      prevMeta  = '0;
      forever begin
         @(negedge clk);
         #2;
         cycleCount++;
         if (!rst_n) begin
            prevStall = 1'b0;
            continue;
         end
         meta = {axis_m_tuser, axis_m_tdest, axis_m_tid, axis_m_tlast};
         if (prevStall) begin
            checkOutput("hold_tvalid", DATAW'(axis_m_tvalid), DATAW'(1));
            checkOutput("hold_tdata", axis_m_tdata, prevData);
            checkOutput("hold_meta", DATAW'(meta), DATAW'(prevMeta));
         end
         if (axis_m_tvalid && axis_m_tready) begin
            lastHsCycle = cycleCount;
            g.data  = axis_m_tdata;
            g.tuser = axis_m_tuser;
            g.tdest = axis_m_tdest;
            g.tid   = axis_m_tid;
            gotQ.push_back(g);
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL extra_beat: got tuser %0h tdest %0h expected no beat", axis_m_tuser, axis_m_tdest);
            end else begin
               e = expQ.pop_front();
               checkOutput("beat_tdata", axis_m_tdata, e.data);
               checkOutput("beat_tuser", DATAW'(axis_m_tuser), DATAW'(e.tuser));
               checkOutput("beat_tdest", DATAW'(axis_m_tdest), DATAW'(e.tdest));
               checkOutput("beat_tid", DATAW'(axis_m_tid), DATAW'(e.tid));
               checkOutput("beat_tlast", DATAW'(axis_m_tlast), DATAW'(1));
            end
         end
         if (done) begin
            doneCount++;
            doneCycle = cycleCount;
         end
         prevStall = axis_m_tvalid && !axis_m_tready;
         prevData  = axis_m_tdata;
         prevMeta  = meta;
      end
   end

   // Builds the expected beat list for a job and pulses START with its config,
   // then scrambles the config inputs to show they are not re-read.
   task automatic applyStimulus(input int nDest, input int nRf, input int nWords,
                                input int destBase, input int destStep, input int addrBase,
                                input int rPct, input int gPct);
      bit    legal;
      bit    zero;
      int    n;
      beat_t b;
      legal = (nRf <= NUM_RF) && (nWords <= (1 << RF_ADDRW));
      zero  = (nDest == 0) || (nRf == 0) || (nWords == 0);
      expTotal = (legal && !zero) ? nDest * nRf * nWords : 0;
      expErr   = !legal;
      expQ.delete();
      gotQ.delete();
      srcWords.delete();
      for (int i = 0; i < expTotal; i++) srcWords.push_back(randWord());
      n = 0;
      if (expTotal > 0) begin
         for (int d = 0; d < nDest; d++)
            for (int r = 0; r < nRf; r++)
               for (int a = 0; a < nWords; a++) begin
                  b.data       = srcWords[n];
                  b.tuser      = '0;
                  b.tuser[8:0] = RF_ADDRW'((addrBase + a) % 512);
                  b.tuser[10:9] = 2'b11;
                  b.tuser[11 + r] = 1'b1;
                  b.tdest      = DESTW'((destBase + d * destStep) % 4096);
                  b.tid        = IDW'(d);
                  expQ.push_back(b);
                  n++;
               end
      end
      srcIdx   = 0;
      readyPct = rPct;
      gapPct   = gPct;
      @(negedge clk);
      cfg_num_dest  = DCNTW'(nDest);
      cfg_num_rf    = RFCNTW'(nRf);
      cfg_num_words = WCNTW'(nWords);
      cfg_dest_base = DESTW'(destBase);
      cfg_dest_step = DESTW'(destStep);
      cfg_addr_base = RF_ADDRW'(addrBase);
      start     = 1'b1;
      srcActive = 1'b1;
      #3;
      startCycle = cycleCount;
      @(negedge clk);
      start         = 1'b0;
      cfg_num_dest  = DCNTW'($urandom);
      cfg_num_rf    = RFCNTW'($urandom);
      cfg_num_words = WCNTW'($urandom);
      cfg_dest_base = DESTW'($urandom);
      cfg_dest_step = DESTW'($urandom);
      cfg_addr_base = RF_ADDRW'($urandom);
   endtask

   // Waits for DONE (bounded) while poking a START into the busy job, then
   // checks the job-level results against the model.
   task automatic waitJobDone(input string name, input int budget);
      int d0;
      int c;
      d0 = doneCount;
      for (c = 0; c < budget; c++) begin
         @(negedge clk);
         #3;
         if (doneCount != d0) break;
         if (c == 5 && busy) begin
            start         = 1'b1;
            cfg_num_words = '0;
            cfg_num_rf    = RFCNTW'(1);
            cfg_num_dest  = DCNTW'(1);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (c == budget) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s_timeout: got no DONE within %0d cycles, required DONE", name, budget);
      end
      repeat (3) @(negedge clk);
      #3;
      srcActive = 1'b0;
      checkOutput({name, "_done_width"}, DATAW'(doneCount - d0), DATAW'(1));
      if (expTotal > 0)
         checkOutput({name, "_done_latency"}, DATAW'(doneCycle), DATAW'(lastHsCycle + 1));
      else
         checkOutput({name, "_done_latency"}, DATAW'(doneCycle), DATAW'(startCycle + 1));
      checkOutput({name, "_beats"}, DATAW'(gotQ.size()), DATAW'(expTotal));
      checkOutput({name, "_missing"}, DATAW'(expQ.size()), DATAW'(0));
      checkOutput({name, "_cfg_err"}, DATAW'(cfg_err), DATAW'(expErr));
      checkOutput({name, "_busy"}, DATAW'(busy), DATAW'(0));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #3;
      checkOutput("reset_tvalid", DATAW'(axis_m_tvalid), DATAW'(0));
      checkOutput("reset_busy", DATAW'(busy), DATAW'(0));
      checkOutput("reset_done", DATAW'(done), DATAW'(0));
      checkOutput("reset_cfg_err", DATAW'(cfg_err), DATAW'(0));
      checkOutput("reset_s_ready", DATAW'(s_ready), DATAW'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // 1 dest, 1 RF, 4 words, always ready
      applyStimulus(1, 1, 4, 0, 0, 0, 100, 0);
      waitJobDone("basic", 200);
      checkOutput("basic_tuser0", DATAW'(gotTuser(0)), DATAW'(75'hE00));
      checkOutput("basic_tuser3", DATAW'(gotTuser(3)), DATAW'(75'hE03));

      // 2 destinations, 64 RFs of 1 word each
      applyStimulus(2, 64, 1, 12'h002, 12'h010, 0, 100, 0);
      waitJobDone("wide", 1000);
      checkOutput("wide_tuser63", DATAW'(gotTuser(63)), DATAW'(75'h4000000000000000600));
      checkOutput("wide_tdest63", DATAW'(gotTdest(63)), DATAW'(12'h002));
      checkOutput("wide_tuser64", DATAW'(gotTuser(64)), DATAW'(75'hE00));
      checkOutput("wide_tdest64", DATAW'(gotTdest(64)), DATAW'(12'h012));

      // 3x4x8 with random backpressure and source gaps
      applyStimulus(3, 4, 8, int'($urandom_range(4095)), int'($urandom_range(4095)),
                    int'($urandom_range(511)), 50, 30);
      waitJobDone("random", 3000);

      // address wrap
      applyStimulus(1, 1, 4, 0, 0, 9'h1FE, 100, 0);
      waitJobDone("wrap", 200);
      checkOutput("wrap_tuser0", DATAW'(gotTuser(0)), DATAW'(75'hFFE));
      checkOutput("wrap_tuser2", DATAW'(gotTuser(2)), DATAW'(75'hE00));
      checkOutput("wrap_tuser3", DATAW'(gotTuser(3)), DATAW'(75'hE01));

      // illegal and empty configurations
      applyStimulus(1, 65, 4, 0, 0, 0, 100, 0);
      waitJobDone("bad_rf", 50);
      applyStimulus(1, 1, 513, 0, 0, 0, 100, 0);
      waitJobDone("bad_words", 50);
      applyStimulus(2, 2, 0, 0, 0, 0, 100, 0);
      waitJobDone("zero_words", 50);

      // a few more small random jobs
      for (int j = 0; j < 3; j++) begin
         applyStimulus(int'($urandom_range(3, 1)), int'($urandom_range(5, 1)), int'($urandom_range(6, 1)),
                       int'($urandom_range(4095)), int'($urandom_range(4095)),
                       int'($urandom_range(511)), 60, 20);
         waitJobDone("rand_small", 2000);
      end

      // asynchronous reset while a beat is stalled on the output
      applyStimulus(2, 8, 8, 5, 7, 3, 0, 0);
      repeat (4) @(negedge clk);
      #3;
      checkOutput("pre_reset_tvalid", DATAW'(axis_m_tvalid), DATAW'(1));
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_tvalid", DATAW'(axis_m_tvalid), DATAW'(0));
      checkOutput("async_rst_busy", DATAW'(busy), DATAW'(0));
      checkOutput("async_rst_s_ready", DATAW'(s_ready), DATAW'(0));
      checkOutput("async_rst_tdata", axis_m_tdata, DATAW'(0));
      checkOutput("async_rst_tuser", DATAW'(axis_m_tuser), DATAW'(0));
      srcActive = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expQ.delete();
      applyStimulus(2, 3, 5, int'($urandom_range(4095)), int'($urandom_range(4095)),
                    int'($urandom_range(511)), 70, 10);
      waitJobDone("after_reset", 2000);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
